// File: rtl/fetch_prefetch_buf.sv
// Prefetching IF stage: one sequential fetch per cycle into a small FIFO, drained by ID via valid/ready.
// Optional macro FETCH_BYPASS_EN lets a response reach ID in its arrival cycle when the FIFO is empty.
module fetch_prefetch_buf #(
  parameter logic [31:0] START_ADDR = 32'hbfc00000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PTR_W      = 2
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst,
  input  logic [32:0]      jbr_bus,
  input  logic [32:0]      exc_bus,
  output logic             IF_valid,
  input  logic             ID_ready,
  output logic [64:0]      IF_ID_bus,
  output logic [31:0]      IF_pc,
  output logic [31:0]      IF_inst,
  output logic [PTR_W:0]   IF_count
);

  logic               resetn_sync;
  logic [31:0]        pc;
  logic               inflight;
  logic [31:0]        req_pc_p1;
  logic               req_err_p1;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count;

  logic [31:0]        mem_pc   [FIFO_DEPTH];
  logic [31:0]        mem_inst [FIFO_DEPTH];
  logic               mem_err  [FIFO_DEPTH];

  logic               exc_valid;
  logic               jbr_taken;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        seq_pc;
  logic [PTR_W+1:0]   credit_used;
  logic               fifo_empty;
  logic               bypass;
  logic               push;
  logic               pop;
  logic [31:0]        out_pc;
  logic [31:0]        out_inst;
  logic               out_err;

  assign exc_valid   = exc_bus[32];
  assign jbr_taken   = jbr_bus[32];
  assign redirect    = exc_valid || jbr_taken;
  assign redirect_pc = exc_valid ? exc_bus[31:0] : jbr_bus[31:0];

  // Only the word index advances, so a misaligned pc stays misaligned.
  assign seq_pc      = {pc[31:2] + 30'd1, pc[1:0]};

  // Every outstanding request already owns a FIFO slot, so a stalled ID cannot overflow it.
  assign credit_used = (PTR_W+2)'(count) + (PTR_W+2)'(inflight);
  assign inst_req    = resetn_sync && (credit_used < (PTR_W+2)'(FIFO_DEPTH)) && !redirect;
  assign inst_addr   = pc;

  assign fifo_empty  = (count == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass   = fifo_empty && inflight;
  assign out_pc   = fifo_empty ? req_pc_p1  : mem_pc[rd_ptr];
  assign out_inst = fifo_empty ? inst       : mem_inst[rd_ptr];
  assign out_err  = fifo_empty ? req_err_p1 : mem_err[rd_ptr];
`else
  assign bypass   = 1'b0;
  assign out_pc   = mem_pc[rd_ptr];
  assign out_inst = mem_inst[rd_ptr];
  assign out_err  = mem_err[rd_ptr];
`endif

  assign IF_valid  = !fifo_empty || bypass;
  assign IF_ID_bus = IF_valid ? {out_pc, out_inst, out_err} : 65'd0;
  assign IF_pc     = IF_ID_bus[64:33];
  assign IF_inst   = IF_ID_bus[32:1];
  assign IF_count  = count;

  assign push = inflight && !(bypass && ID_ready);
  assign pop  = !fifo_empty && ID_ready;

  // Stage p0 -> p1: request issue, pc advance and FIFO bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resetn_sync <= 1'b0;
      pc          <= START_ADDR;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      resetn_sync <= 1'b1;
      if (redirect) begin
        pc       <= redirect_pc;
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (inst_req) pc <= seq_pc;
        inflight <= inst_req;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inst_req) begin
      req_pc_p1  <= pc;
      req_err_p1 <= (pc[1:0] != 2'b00);
    end
  end

  // Stage p1 -> p2: returning instruction written into the FIFO
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      mem_pc[wr_ptr]   <= req_pc_p1;
      mem_inst[wr_ptr] <= inst;
      mem_err[wr_ptr]  <= req_err_p1;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buf.sv
// Directed + random bench for fetch_prefetch_buf against a queue-based reference model.
module tb_fetch_prefetch_buf;

  localparam logic [31:0] START = 32'hbfc00000;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic          clk;
  logic          resetn;
  logic          inst_req;
  logic [31:0]   inst_addr;
  logic [31:0]   inst;
  logic [32:0]   jbr_bus;
  logic [32:0]   exc_bus;
  logic          IF_valid;
  logic          ID_ready;
  logic [64:0]   IF_ID_bus;
  logic [31:0]   IF_pc;
  logic [31:0]   IF_inst;
  logic [PW:0]   IF_count;

  fetch_prefetch_buf #(.START_ADDR(START), .FIFO_DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst(inst), .jbr_bus(jbr_bus), .exc_bus(exc_bus), .IF_valid(IF_valid),
    .ID_ready(ID_ready), .IF_ID_bus(IF_ID_bus), .IF_pc(IF_pc), .IF_inst(IF_inst),
    .IF_count(IF_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  bit          m_pend;
  bit          m_ready;
  logic [64:0] q[$];

  int n_chk;
  int n_fail;
  int cyc;

  logic        o_req;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [64:0] o_bus;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h5a5a5a5a;
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = START;
    m_pend = 1'b0;
    m_ready = 1'b0;
    q.delete();
  endtask

  task automatic step();
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic        e_valid;
    logic [64:0] head;
    logic [64:0] e_bus;
    logic [64:0] entry;
    logic [31:0] rom_next;
    bit          had;
    @(negedge clk);
    redir   = exc_bus[32] || jbr_bus[32];
    tgt     = exc_bus[32] ? exc_bus[31:0] : jbr_bus[31:0];
    e_req   = m_ready && (q.size() + int'(m_pend) < DEPTH) && !redir;
    e_valid = (q.size() != 0) || (BYP && m_pend);
    entry   = {m_pend_pc, inst, (m_pend_pc[1:0] != 2'b00)};
    head    = (q.size() != 0) ? q[0] : entry;
    e_bus   = e_valid ? head : 65'd0;
    chk("inst_req",  65'(inst_req),  65'(e_req));
    chk("inst_addr", 65'(inst_addr), 65'(m_pc));
    chk("IF_valid",  65'(IF_valid),  65'(e_valid));
    chk("IF_ID_bus", IF_ID_bus,      e_bus);
    chk("IF_pc",     65'(IF_pc),     65'(e_bus[64:33]));
    chk("IF_inst",   65'(IF_inst),   65'(e_bus[32:1]));
    chk("IF_count",  65'(IF_count),  65'(q.size()));
    o_req = inst_req; o_valid = IF_valid; o_addr = inst_addr; o_bus = IF_ID_bus;
    rom_next = inst_req ? rom(inst_addr) : $urandom;
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      model_reset();
    end else begin
      if (redir) begin
        q.delete();
        m_pend = 1'b0;
        m_pc = tgt;
      end else begin
        had = (q.size() != 0);
        if (had && ID_ready) void'(q.pop_front());
        if (m_pend && !(!had && BYP && ID_ready)) q.push_back(entry);
        m_pend = e_req;
        if (e_req) begin
          m_pend_pc = m_pc;
          m_pc = {m_pc[31:2] + 30'd1, m_pc[1:0]};
        end
      end
      m_ready = 1'b1;
    end
    #1;
    inst = rom_next;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic check_restart(input string tag);
    int first_req;
    int first_vld;
    first_req = -1;
    first_vld = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_req && first_req < 0) begin
        first_req = cyc;
        chk({tag, "_first_addr"}, 65'(o_addr), 65'(START));
      end
      if (o_valid && first_vld < 0) first_vld = cyc;
    end
    chk({tag, "_latency"}, 65'(first_vld - first_req), 65'(LAT));
  endtask

  initial begin
    int          found;
    int          c1;
    int          c2;
    int          got;
    bit          saw_zero;
    logic [64:0] b1;
    logic [64:0] b2;
    logic [31:0] t;
    int          r;
    n_chk = 0; n_fail = 0; cyc = 0;
    resetn = 1'b1; ID_ready = 1'b1; jbr_bus = '0; exc_bus = '0; inst = '0;
    m_pend_pc = '0;
    #1;
    resetn = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_count", 65'(IF_count), 65'd0);
    chk("rst_bus",   IF_ID_bus,     65'd0);
    resetn = 1'b1;

    // Streaming with ID always ready
    check_restart("stream");

    // ID stalled from reset: FIFO saturates, pc holds
    do_reset();
    ID_ready = 1'b0;
    repeat (10) step();
    chk("full_count", 65'(IF_count),  65'd4);
    chk("full_req",   65'(inst_req),  65'd0);
    chk("full_pc",    65'(inst_addr), 65'(32'hbfc00010));
    ID_ready = 1'b1;
    step();
    chk("drain_first_pc", 65'(o_bus[64:33]), 65'(START));
    repeat (12) step();

    // Branch with 3 buffered entries and a fetch in flight
    do_reset();
    ID_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (q.size() == 3 && m_pend) found = 1;
    end
    chk("jbr_setup_reached", 65'(found), 65'd1);
    jbr_bus = {1'b1, 32'hbfc00100};
    step();
    jbr_bus = '0;
    chk("jbr_flush_valid", 65'(IF_valid), 65'd0);
    chk("jbr_next_addr", 65'(inst_addr), 65'(32'hbfc00100));
    ID_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (o_valid) begin
        found = 1;
        chk("jbr_first_out_pc", 65'(o_bus[64:33]), 65'(32'hbfc00100));
      end
    end
    chk("jbr_out_seen", 65'(found), 65'd1);

    // Exception beats a same-cycle branch
    exc_bus = {1'b1, 32'hbfc00380};
    jbr_bus = {1'b1, 32'hbfc00100};
    step();
    exc_bus = '0; jbr_bus = '0;
    chk("exc_priority_pc", 65'(inst_addr), 65'(32'hbfc00380));
    repeat (4) step();

    // Misaligned target: entries flagged, stream keeps flowing
    jbr_bus = {1'b1, 32'hbfc00102};
    step();
    jbr_bus = '0;
    got = 0; c1 = 0; c2 = 0; b1 = '0; b2 = '0;
    for (int i = 0; i < 10 && got < 2; i++) begin
      step();
      if (o_valid) begin
        if (got == 0) begin b1 = o_bus; c1 = cyc; end
        else begin b2 = o_bus; c2 = cyc; end
        got++;
      end
    end
    chk("mis_pc0",  65'(b1[64:33]), 65'(32'hbfc00102));
    chk("mis_err0", 65'(b1[0]),     65'd1);
    chk("mis_pc1",  65'(b2[64:33]), 65'(32'hbfc00106));
    chk("mis_err1", 65'(b2[0]),     65'd1);
    chk("mis_back_to_back", 65'(c2 - c1), 65'd1);

    // Address wrap at the top of the space
    jbr_bus = {1'b1, 32'hfffffff8};
    step();
    jbr_bus = '0;
    saw_zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_req && o_addr == 32'h0) saw_zero = 1'b1;
    end
    chk("wrap_to_zero", 65'(saw_zero), 65'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ID_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      jbr_bus = (r == 0 || r == 2) ? {1'b1, t} : {1'b0, 32'h0};
      exc_bus = (r == 1 || r == 2) ? {1'b1, 32'hbfc00380} : {1'b0, 32'h0};
      step();
    end
    jbr_bus = '0; exc_bus = '0;

    // Asynchronous reset with the FIFO full
    ID_ready = 1'b0;
    repeat (8) step();
    chk("pre_rst_full", 65'(IF_count), 65'd4);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 65'(IF_valid), 65'd0);
    chk("arst_req",   65'(inst_req), 65'd0);
    chk("arst_count", 65'(IF_count), 65'd0);
    model_reset();
    step();
    step();
    resetn = 1'b1;
    ID_ready = 1'b1;
    check_restart("post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_buf.md
Name: fetch_prefetch_buf

Overview:
- Next-generation IF stage for the five-stage MIPS pipeline. Replaces the single-entry, next_fetch-locked PC.
- Issues one sequential fetch per cycle to the synchronous inst_rom (1-cycle read latency) and buffers returned instructions in a parametrised FIFO.
- Presents them to ID with a valid/ready handshake.
- Redirects from exceptions and branches flush the FIFO and drop any in-flight fetch.

Parameters:
START_ADDR, 32'hbfc00000, PC value loaded at reset
FIFO_DEPTH, 4, number of buffered instruction entries (power of 2, >=2)
PTR_W, 2, log2(FIFO_DEPTH); pointer width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
inst_req  out  1  fetch request to inst_rom this cycle
inst_addr  out  32  fetch address (current pc)
inst  in  32  inst_rom read data, valid the cycle after inst_req
jbr_bus  in  33  {jbr_taken, jbr_target} from ID
exc_bus  in  33  {exc_valid, exc_pc} from WB/exception unit
IF_valid  out  1  IF_ID_bus holds a valid entry
ID_ready  in  1  ID accepts the entry this cycle
IF_ID_bus  out  65  {pc, inst, fetch_error} of the FIFO head
IF_pc  out  32  pc of the FIFO head (display)
IF_inst  out  32  inst of the FIFO head (display)
IF_count  out  PTR_W+1  FIFO occupancy (debug)

Behaviour:
- Reset (async, resetn=0):
  - pc=START_ADDR; FIFO empty (rd_ptr=wr_ptr=0, count=0); inflight=0.
  - inst_req=0, IF_valid=0, IF_ID_bus=0, IF_count=0.
- Credits:
  - inst_req = resetn_sync && (count + inflight < FIFO_DEPTH) && !redirect.
  - This guarantees no overflow even if ID stalls.
- Request and PC update:
  - inst_addr=pc.
  - On inst_req: pc <= seq_pc, where seq_pc[31:2]=pc[31:2]+1 and seq_pc[1:0]=pc[1:0].
  - Also: inflight <= 1, req_pc <= pc, req_err <= (pc[1:0]!=0).
  - pc wraps 32'hfffffffc -> 32'h00000000 (natural overflow).
- Response:
  - The cycle after a request (inflight=1), push {req_pc, inst, req_err} at wr_ptr.
  - inflight clears unless a new request is issued in the same cycle.
- Misaligned pc:
  - The request is still issued.
  - The entry carries fetch_error=1; inst is passed through unmodified.
- Output:
  - IF_valid = (count!=0); the head is at rd_ptr.
  - Pop when IF_valid && ID_ready.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
- Redirect:
  - redirect = exc_valid || jbr_taken. exc_valid has priority over jbr_taken.
  - Effect at the clock edge:
    - pc <= exc_pc or jbr_target.
    - FIFO flushed (count=0, rd_ptr=wr_ptr).
    - inflight cleared; any response arriving next cycle is discarded.
    - No request issued that cycle.
  - Redirect wins over a same-cycle pop, push and request.
  - The first request to the target is issued the cycle after the redirect.
- Latency:
  - Request at cycle N, data at N+1, IF_valid at N+2 (no bypass).
  - Sustained throughput is 1 instruction/cycle when ID_ready=1 and FIFO_DEPTH>=2.
- Full:
  - At count=FIFO_DEPTH, inst_req=0 and pc holds.
  - At count=FIFO_DEPTH-1 with inflight=1, no new request is issued.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), including the in-flight tag.

Optional Feature:
FETCH_BYPASS_EN:
- Defined:
  - When the FIFO is empty and a valid (non-flushed) response arrives, it drives IF_ID_bus combinationally with IF_valid=1 in that same cycle.
  - If ID_ready=1, it is consumed without being written; otherwise it is pushed.
  - Fetch-to-ID latency drops to N+1.
- Undefined: all responses go through the FIFO; latency N+2; no combinational path from inst to IF_ID_bus.

Test Plan:
- Reset release, ID_ready=1, ROM returns inst = addr ^ 32'h5a5a5a5a:
  - inst_addr sequence 0xbfc00000, 0xbfc00004, ...
  - IF_valid first high 2 cycles after the first inst_req.
  - Thereafter one entry per cycle in order.
- ID_ready=0 from reset: IF_count saturates at 4, inst_req stays low, pc holds at 0xbfc00010. Release ID_ready: entries 0xbfc00000..0xbfc0000c emerge in order, then fetch resumes.
- jbr_bus={1,32'hbfc00100} with FIFO holding 3 entries and inflight=1: next cycle IF_valid=0 and the in-flight response is discarded. Next inst_addr=0xbfc00100; the first output pc is 0xbfc00100.
- exc_bus={1,32'hbfc00380} and jbr_bus={1,32'hbfc00100} in the same cycle: pc becomes 0xbfc00380.
- jbr_target=32'hbfc00102: entries carry fetch_error=1 with pcs 0xbfc00102, 0xbfc00106; the fetch stream does not stall.
- resetn asserted low mid-stream with FIFO full: IF_valid, inst_req and IF_count are 0 immediately. After release, inst_addr restarts at 0xbfc00000. With FETCH_BYPASS_EN defined, the first IF_valid follows the first inst_req by 1 cycle.
